bus_interconnect: RTL and testbench

BUS_INTERCONNECT -- requirements
Module: bus_interconnect

---
 rtl/bus_interconnect.sv | 141 ++++++++++++++
 tb/tb_bus_interconnect.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_interconnect.sv
// Routes one master to two slaves by address; reads return in order through a tag FIFO.
// Read data is registered one cycle after the pop; m_ready drops on a busy slave or a full tag FIFO.
module bus_interconnect #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        m_ready,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_write_data,
    input  logic [3:0]  m_byte_enable,
    input  logic        m_write_req,
    input  logic        m_read_req,
    output logic [31:0] m_read_data,
    output logic        m_read_data_valid,
    input  logic        s0_ready,
    output logic [31:0] s0_addr,
    output logic [31:0] s0_write_data,
    output logic [3:0]  s0_byte_enable,
    output logic        s0_write_req,
    output logic        s0_read_req,
    input  logic [31:0] s0_read_data,
    input  logic        s0_read_data_valid,
    input  logic        s1_ready,
    output logic [31:0] s1_addr,
    output logic [31:0] s1_write_data,
    output logic [3:0]  s1_byte_enable,
    output logic        s1_write_req,
    output logic        s1_read_req,
    input  logic [31:0] s1_read_data,
    input  logic        s1_read_data_valid,
    output logic        bus_error
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] TAG_S0  = 2'd0;
    localparam logic [1:0] TAG_S1  = 2'd1;
    localparam logic [1:0] TAG_UNM = 2'd2;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

    logic [1:0]    r_tags [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_rdata;
    logic          r_rvld;
    logic          r_err;

    logic       w_sel0, w_sel1, w_unm;
    logic       w_wr, w_rd;
    logic       w_full, w_empty;
    logic       w_ready;
    logic       w_push, w_pop;
    logic [1:0] w_push_tag, w_head;
    logic       w_stray0, w_stray1, w_err;

    assign w_sel0  = (m_addr[31:28] == 4'h1);
    assign w_sel1  = (m_addr[31:28] == 4'h2);
    assign w_unm   = ~w_sel0 & ~w_sel1;
    // A simultaneous read+write is a write only.
    assign w_wr    = m_write_req;
    assign w_rd    = m_read_req & ~m_write_req;
    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_head  = r_tags[r_rptr];

    assign s0_addr        = m_addr;
    assign s0_write_data  = m_write_data;
    assign s0_byte_enable = m_byte_enable;
    assign s1_addr        = m_addr;
    assign s1_write_data  = m_write_data;
    assign s1_byte_enable = m_byte_enable;

    assign s0_write_req = w_wr & w_sel0;
    assign s1_write_req = w_wr & w_sel1;
    assign s0_read_req  = w_rd & w_sel0 & ~w_full;
    assign s1_read_req  = w_rd & w_sel1 & ~w_full;

    always_comb begin
        w_ready = 1'b1;
        if (w_wr) begin
            if (w_sel0)      w_ready = s0_ready;
            else if (w_sel1) w_ready = s1_ready;
        end else if (w_rd) begin
            if (w_sel0)      w_ready = s0_ready & ~w_full;
            else if (w_sel1) w_ready = s1_ready & ~w_full;
            else             w_ready = ~w_full;
        end
    end
    assign m_ready = w_ready;

    assign w_push     = w_rd & w_ready;
    assign w_push_tag = w_sel0 ? TAG_S0 : (w_sel1 ? TAG_S1 : TAG_UNM);
    // Unmapped heads retire without waiting on any slave.
    assign w_pop      = ~w_empty & (((w_head == TAG_S0) & s0_read_data_valid) |
                                    ((w_head == TAG_S1) & s1_read_data_valid) |
                                    (w_head == TAG_UNM));
    assign w_stray0   = s0_read_data_valid & (w_empty | (w_head != TAG_S0));
    assign w_stray1   = s1_read_data_valid & (w_empty | (w_head != TAG_S1));
    assign w_err      = (w_wr & w_unm) | (w_push & w_unm) | w_stray0 | w_stray1;

    always_ff @(posedge clk) begin
        if (w_push) r_tags[r_wptr] <= w_push_tag;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
            r_rvld  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_rvld <= w_pop;
            if (w_pop) begin
                if (w_head == TAG_S0)      r_rdata <= s0_read_data;
                else if (w_head == TAG_S1) r_rdata <= s1_read_data;
                else                       r_rdata <= 32'h0;
            end
            if (w_err) r_err <= 1'b1;
        end
    end

    assign m_read_data       = r_rdata;
    assign m_read_data_valid = r_rvld;
    assign bus_error         = r_err;
endmodule

// File: tb/tb_bus_interconnect.sv
// Directed bench for bus_interconnect; expected read data is queued when stimulus is driven.
module tb_bus_interconnect;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        m_ready;
    logic [31:0] m_addr, m_write_data, m_read_data;
    logic [3:0]  m_byte_enable;
    logic        m_write_req, m_read_req, m_read_data_valid;
    logic        s0_ready, s0_write_req, s0_read_req, s0_read_data_valid;
    logic [31:0] s0_addr, s0_write_data, s0_read_data;
    logic [3:0]  s0_byte_enable;
    logic        s1_ready, s1_write_req, s1_read_req, s1_read_data_valid;
    logic [31:0] s1_addr, s1_write_data, s1_read_data;
    logic [3:0]  s1_byte_enable;
    logic        bus_error;

    logic [31:0] sb[$];
    int checks = 0;
    int failures = 0;

    bus_interconnect #(.DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .m_ready(m_ready),
        .m_addr(m_addr), .m_write_data(m_write_data), .m_byte_enable(m_byte_enable),
        .m_write_req(m_write_req), .m_read_req(m_read_req),
        .m_read_data(m_read_data), .m_read_data_valid(m_read_data_valid),
        .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_write_data(s0_write_data),
        .s0_byte_enable(s0_byte_enable), .s0_write_req(s0_write_req), .s0_read_req(s0_read_req),
        .s0_read_data(s0_read_data), .s0_read_data_valid(s0_read_data_valid),
        .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_write_data(s1_write_data),
        .s1_byte_enable(s1_byte_enable), .s1_write_req(s1_write_req), .s1_read_req(s1_read_req),
        .s1_read_data(s1_read_data), .s1_read_data_valid(s1_read_data_valid),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every response that appears is matched against the oldest queued expectation.
    task automatic tick();
        @(posedge clk);
        #1;
        if (m_read_data_valid) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL sb_underflow observed=response expected=none_pending");
            end
            if (sb.size() != 0) chk32("rdata_sb", m_read_data, sb.pop_front());
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        chk32("rst_rdata", m_read_data, 32'h0);
        chk1("rst_rvld", m_read_data_valid, 1'b0);
        chk1("rst_err", bus_error, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        m_addr = '0; m_write_data = '0; m_byte_enable = '0;
        m_write_req = 1'b0; m_read_req = 1'b0;
        s0_ready = 1'b1; s1_ready = 1'b1;
        s0_read_data = '0; s1_read_data = '0;
        s0_read_data_valid = 1'b0; s1_read_data_valid = 1'b0;
        reset_n = 1'b0;
        #2;
        chk1("rst_idle_ready", m_ready, 1'b1);
        chk1("rst_idle_s0rd", s0_read_req, 1'b0);
        do_reset();

        // s0 read, return two cycles after acceptance
        m_addr = 32'h1000_0000; m_read_req = 1'b1;
        #1;
        chk1("rd0_ready", m_ready, 1'b1);
        chk1("rd0_s0rd", s0_read_req, 1'b1);
        chk1("rd0_s1rd", s1_read_req, 1'b0);
        tick(); m_read_req = 1'b0;
        tick();
        s0_read_data = 32'hDEAD_BEEF; s0_read_data_valid = 1'b1; sb.push_back(32'hDEAD_BEEF);
        tick(); s0_read_data_valid = 1'b0;
        chk1("rd0_rvld", m_read_data_valid, 1'b1);
        chk1("rd0_err", bus_error, 1'b0);
        s0_read_data = 32'h1111_2222;
        tick();
        chk1("rd0_rvld_drop", m_read_data_valid, 1'b0);
        chk32("rd0_hold", m_read_data, 32'hDEAD_BEEF);

        // s1 write stalled three cycles
        m_addr = 32'h2000_0004; m_write_data = 32'h55; m_byte_enable = 4'h1;
        m_write_req = 1'b1; s1_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("wr1_stall_ready", m_ready, 1'b0);
            chk1("wr1_s1wr", s1_write_req, 1'b1);
            chk1("wr1_s0wr", s0_write_req, 1'b0);
            tick();
        end
        chk32("pass_s1addr", s1_addr, 32'h2000_0004);
        chk32("pass_s0wdata", s0_write_data, 32'h55);
        chk32("pass_s1be", {28'h0, s1_byte_enable}, 32'h1);
        s1_ready = 1'b1;
        #1;
        chk1("wr1_ready", m_ready, 1'b1);
        tick(); m_write_req = 1'b0;
        chk1("wr1_err", bus_error, 1'b0);

        // read+write together acts as a write only
        m_addr = 32'h1000_0008; m_read_req = 1'b1; m_write_req = 1'b1;
        #1;
        chk1("rw_s0rd", s0_read_req, 1'b0);
        chk1("rw_s0wr", s0_write_req, 1'b1);
        tick(); m_read_req = 1'b0; m_write_req = 1'b0;
        #1;
        chk1("idle_ready", m_ready, 1'b1);
        chk1("idle_s0wr", s0_write_req, 1'b0);
        chk1("idle_s1rd", s1_read_req, 1'b0);
        tick(); tick();
        chk1("rw_no_resp", m_read_data_valid, 1'b0);

        // unmapped read returns zero
        m_addr = 32'h3000_0000; m_read_req = 1'b1;
        #1;
        chk1("unm_rd_ready", m_ready, 1'b1);
        chk1("unm_rd_s0rd", s0_read_req, 1'b0);
        chk1("unm_rd_s1rd", s1_read_req, 1'b0);
        sb.push_back(32'h0);
        tick(); m_read_req = 1'b0;
        chk1("unm_rd_rvld_early", m_read_data_valid, 1'b0);
        chk1("unm_rd_err", bus_error, 1'b1);
        tick();
        chk1("unm_rd_rvld", m_read_data_valid, 1'b1);
        chk32("unm_rd_data", m_read_data, 32'h0);

        // unmapped write
        do_reset();
        m_addr = 32'hF000_0000; m_write_req = 1'b1;
        #1;
        chk1("unm_wr_ready", m_ready, 1'b1);
        chk1("unm_wr_s0wr", s0_write_req, 1'b0);
        chk1("unm_wr_s1wr", s1_write_req, 1'b0);
        tick(); m_write_req = 1'b0;
        chk1("unm_wr_err", bus_error, 1'b1);

        // s0, s1, s0 with s1 returning out of order
        do_reset();
        m_read_req = 1'b1;
        m_addr = 32'h1000_0000; tick();
        m_addr = 32'h2000_0000; tick();
        m_addr = 32'h1000_0004; tick();
        m_read_req = 1'b0;
        chk1("ooo_err_before", bus_error, 1'b0);
        s1_read_data = 32'h0000_000B; s1_read_data_valid = 1'b1;
        tick(); s1_read_data_valid = 1'b0;
        chk1("ooo_stray_rvld", m_read_data_valid, 1'b0);
        chk1("ooo_err", bus_error, 1'b1);
        s0_read_data = 32'hAAAA_0001; s0_read_data_valid = 1'b1; sb.push_back(32'hAAAA_0001);
        tick(); s0_read_data_valid = 1'b0;
        chk1("ooo_rvld0", m_read_data_valid, 1'b1);
        s1_read_data = 32'hBBBB_0002; s1_read_data_valid = 1'b1; sb.push_back(32'hBBBB_0002);
        tick(); s1_read_data_valid = 1'b0;
        chk1("ooo_rvld1", m_read_data_valid, 1'b1);
        s0_read_data = 32'hCCCC_0003; s0_read_data_valid = 1'b1; sb.push_back(32'hCCCC_0003);
        tick(); s0_read_data_valid = 1'b0;
        chk1("ooo_rvld2", m_read_data_valid, 1'b1);

        // fill the tag FIFO, then free one slot with a concurrent return
        m_addr = 32'h1000_0010; m_read_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1("fill_ready", m_ready, 1'b1);
            tick();
        end
        #1;
        chk1("full_ready", m_ready, 1'b0);
        chk1("full_s0rd", s0_read_req, 1'b0);
        s0_read_data = 32'h4300_0000; s0_read_data_valid = 1'b1; sb.push_back(32'h4300_0000);
        tick(); s0_read_data_valid = 1'b0;
        chk1("full_pop_rvld", m_read_data_valid, 1'b1);
        chk1("refill_ready", m_ready, 1'b1);
        chk1("refill_s0rd", s0_read_req, 1'b1);
        tick(); m_read_req = 1'b0;
        for (int i = 1; i < 5; i++) begin
            s0_read_data = 32'h4300_0000 + 32'(i); s0_read_data_valid = 1'b1;
            sb.push_back(32'h4300_0000 + 32'(i));
            tick();
            chk1("drain_rvld", m_read_data_valid, 1'b1);
        end
        s0_read_data_valid = 1'b0;
        tick();
        chk1("drain_done", m_read_data_valid, 1'b0);

        // reset with reads outstanding discards their tags
        m_addr = 32'h1000_0000; m_read_req = 1'b1;
        tick(); tick(); m_read_req = 1'b0;
        do_reset();
        s0_read_data = 32'h45; s0_read_data_valid = 1'b1;
        tick(); s0_read_data_valid = 1'b0;
        chk1("postrst_rvld", m_read_data_valid, 1'b0);
        chk1("postrst_err", bus_error, 1'b1);
        chk32("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
